// File: rtl/if_fetch_stage_if.sv
// rtl/if_fetch_stage_if.sv - instruction-memory request/response bundle between fetch stage and imem
interface if_fetch_stage_if;
   logic        req;
   logic [31:0] addr;
   logic        ready;
   logic [31:0] rdata;

   modport master (output req, output addr, input ready, input rdata);
   modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch stage with IF/ID register, one-word hold buffer and branch redirect
// Optional stall-cycle counter port enabled by macro IF_STALL_COUNT_EN.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                Freeze,
   input  logic                Branch_taken,
   input  logic [31:0]         Branch_address,
   if_fetch_stage_if.master    imem,
   output logic [31:0]         PC_out,
   output logic [31:0]         instruction_out,
   output logic                valid_out
`ifdef IF_STALL_COUNT_EN
   ,
   output logic [31:0]         stall_count
`endif
);

   typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

   state_t      state;
   logic        req_q;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] hold_pc;
   logic [31:0] hold_instr;

   assign pc_plus4  = pc + 32'd4;
   assign imem.addr = pc;
   assign imem.req  = req_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= FETCH;
         req_q           <= 1'b1;
         pc              <= RESET_PC;
         hold_pc         <= 32'd0;
         hold_instr      <= 32'd0;
         PC_out          <= 32'd0;
         instruction_out <= 32'd0;
         valid_out       <= 1'b0;
      end else if (Branch_taken) begin
         // Redirect wins over everything: any word accepted this cycle and the held word are dropped.
         state           <= FETCH;
         req_q           <= 1'b1;
         pc              <= Branch_address;
         hold_pc         <= 32'd0;
         hold_instr      <= 32'd0;
         instruction_out <= 32'd0;
         valid_out       <= 1'b0;
      end else begin
         case (state)
            FETCH: begin
               if (imem.ready) begin
                  pc <= pc_plus4;
                  if (Freeze) begin
                     // Memory already returned the word; park it so the request is not repeated.
                     hold_pc    <= pc_plus4;
                     hold_instr <= imem.rdata;
                     state      <= HOLD;
                     req_q      <= 1'b0;
                  end else begin
                     PC_out          <= pc_plus4;
                     instruction_out <= imem.rdata;
                     valid_out       <= 1'b1;
                  end
               end else if (!Freeze) begin
                  instruction_out <= 32'd0;
                  valid_out       <= 1'b0;
               end
            end
            HOLD: begin
               if (!Freeze) begin
                  PC_out          <= hold_pc;
                  instruction_out <= hold_instr;
                  valid_out       <= 1'b1;
                  state           <= FETCH;
                  req_q           <= 1'b1;
               end
            end
            default: begin
               state <= FETCH;
               req_q <= 1'b1;
            end
         endcase
      end
   end

`ifdef IF_STALL_COUNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_count <= 32'd0;
      end else if ((Freeze || (state == FETCH && !imem.ready)) && stall_count != 32'hFFFF_FFFF) begin
         stall_count <= stall_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - vector table and scoreboard bench for if_fetch_stage
module tb_if_fetch_stage;

   typedef struct {
      logic        rst;
      logic        freeze;
      logic        br;
      logic [31:0] ba;
      logic        rdy;
      logic [31:0] rd;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_instr;
      logic [31:0] e_pc;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        Freeze;
   logic        Branch_taken;
   logic [31:0] Branch_address;
   logic [31:0] PC_out;
   logic [31:0] instruction_out;
   logic        valid_out;
`ifdef IF_STALL_COUNT_EN
   logic [31:0] stall_count;
`endif

   if_fetch_stage_if imem ();

   if_fetch_stage dut (
      .clk             (clk),
      .rst             (rst),
      .Freeze          (Freeze),
      .Branch_taken    (Branch_taken),
      .Branch_address  (Branch_address),
      .imem            (imem.master),
      .PC_out          (PC_out),
      .instruction_out (instruction_out),
      .valid_out       (valid_out)
`ifdef IF_STALL_COUNT_EN
      ,
      .stall_count     (stall_count)
`endif
   );

   always #5 clk = ~clk;

   int   n_cmp = 0;
   int   n_err = 0;
   vec_t vecs[$];
   vec_t sb[$];
   int   step_no = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step(input vec_t v);
      vec_t e;
      @(negedge clk);
      rst            = v.rst;
      Freeze         = v.freeze;
      Branch_taken   = v.br;
      Branch_address = v.ba;
      imem.ready     = v.rdy;
      imem.rdata     = v.rd;
      sb.push_back(v);
      @(posedge clk);
      #1;
      step_no++;
      if (sb.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL scoreboard_empty step %0d", step_no);
      end else begin
         e = sb.pop_front();
         chk($sformatf("s%0d imem_req", step_no),        {31'd0, imem.req},   {31'd0, e.e_req});
         chk($sformatf("s%0d imem_addr", step_no),       imem.addr,           e.e_addr);
         chk($sformatf("s%0d valid_out", step_no),       {31'd0, valid_out},  {31'd0, e.e_valid});
         chk($sformatf("s%0d instruction_out", step_no), instruction_out,     e.e_instr);
         chk($sformatf("s%0d PC_out", step_no),          PC_out,              e.e_pc);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; Freeze = 1'b0; Branch_taken = 1'b0; Branch_address = 32'd0;
      imem.ready = 1'b0; imem.rdata = 32'd0;

      //                rst fr br ba           rdy rd            req addr          v  instr         pc_out
      vecs.push_back('{1'b1,1'b0,1'b0,32'h0,       1'b0,32'h0,        1'b1,32'h0,        1'b0,32'h0,        32'h0});
      vecs.push_back('{1'b0,1'b0,1'b0,32'h0,       1'b1,32'hE3A0_1005,1'b1,32'h4,        1'b1,32'hE3A0_1005,32'h4});
      vecs.push_back('{1'b0,1'b0,1'b0,32'h0,       1'b1,32'h1111_1111,1'b1,32'h8,        1'b1,32'h1111_1111,32'h8});
      vecs.push_back('{1'b0,1'b1,1'b0,32'h0,       1'b1,32'h2222_2222,1'b0,32'hC,        1'b1,32'h1111_1111,32'h8});
      vecs.push_back('{1'b0,1'b1,1'b0,32'h0,       1'b1,32'h9999_9999,1'b0,32'hC,        1'b1,32'h1111_1111,32'h8});
      vecs.push_back('{1'b0,1'b1,1'b0,32'h0,       1'b1,32'h9999_9999,1'b0,32'hC,        1'b1,32'h1111_1111,32'h8});
      vecs.push_back('{1'b0,1'b0,1'b0,32'h0,       1'b1,32'h9999_9999,1'b1,32'hC,        1'b1,32'h2222_2222,32'hC});
      vecs.push_back('{1'b0,1'b0,1'b0,32'h0,       1'b1,32'h3333_3333,1'b1,32'h10,       1'b1,32'h3333_3333,32'h10});
      vecs.push_back('{1'b0,1'b0,1'b0,32'h0,       1'b0,32'hDEAD_0001,1'b1,32'h10,       1'b0,32'h0,        32'h10});
      vecs.push_back('{1'b0,1'b0,1'b0,32'h0,       1'b0,32'hDEAD_0002,1'b1,32'h10,       1'b0,32'h0,        32'h10});
      vecs.push_back('{1'b0,1'b0,1'b0,32'h0,       1'b1,32'h4444_4444,1'b1,32'h14,       1'b1,32'h4444_4444,32'h14});
      vecs.push_back('{1'b0,1'b1,1'b0,32'h0,       1'b0,32'hDEAD_0003,1'b1,32'h14,       1'b1,32'h4444_4444,32'h14});
      vecs.push_back('{1'b0,1'b1,1'b0,32'h0,       1'b1,32'h5555_5555,1'b0,32'h18,       1'b1,32'h4444_4444,32'h14});
      vecs.push_back('{1'b0,1'b1,1'b1,32'h40,      1'b1,32'h6666_6666,1'b1,32'h40,       1'b0,32'h0,        32'h14});
      vecs.push_back('{1'b0,1'b0,1'b0,32'h0,       1'b1,32'h7777_7777,1'b1,32'h44,       1'b1,32'h7777_7777,32'h44});
      vecs.push_back('{1'b0,1'b0,1'b1,32'h100,     1'b1,32'h8888_8888,1'b1,32'h100,      1'b0,32'h0,        32'h44});
      vecs.push_back('{1'b0,1'b0,1'b0,32'h0,       1'b1,32'hAAAA_AAAA,1'b1,32'h104,      1'b1,32'hAAAA_AAAA,32'h104});
      vecs.push_back('{1'b0,1'b1,1'b0,32'h0,       1'b1,32'hBBBB_BBBB,1'b0,32'h108,      1'b1,32'hAAAA_AAAA,32'h104});
      vecs.push_back('{1'b1,1'b1,1'b1,32'h200,     1'b1,32'hBBBB_BBBB,1'b1,32'h0,        1'b0,32'h0,        32'h0});
      vecs.push_back('{1'b0,1'b0,1'b0,32'h0,       1'b1,32'hCCCC_CCCC,1'b1,32'h4,        1'b1,32'hCCCC_CCCC,32'h4});

      for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

      // PC wrap at the top of the address space
      step('{1'b0,1'b0,1'b1,32'hFFFF_FFFC,1'b0,32'h0,        1'b1,32'hFFFF_FFFC,1'b0,32'h0,        32'h4});
      step('{1'b0,1'b0,1'b0,32'h0,        1'b1,32'hDDDD_DDDD,1'b1,32'h0,        1'b1,32'hDDDD_DDDD,32'h0});
      step('{1'b0,1'b0,1'b0,32'h0,        1'b1,32'h0000_0001,1'b1,32'h4,        1'b1,32'h0000_0001,32'h4});

      // Stall counting: 5 frozen cycles, one release, 2 not-ready cycles, then reset
      step('{1'b1,1'b0,1'b0,32'h0,1'b0,32'h0,1'b1,32'h0,1'b0,32'h0,32'h0});
`ifdef IF_STALL_COUNT_EN
      chk("stall_count_after_reset", stall_count, 32'd0);
`endif
      for (int i = 0; i < 5; i++)
         step('{1'b0,1'b1,1'b0,32'h0,1'b1,32'hF0F0_F0F0,1'b0,32'h4,1'b0,32'h0,32'h0});
      step('{1'b0,1'b0,1'b0,32'h0,1'b1,32'h1234_5678,1'b1,32'h4,1'b1,32'hF0F0_F0F0,32'h4});
      for (int i = 0; i < 2; i++)
         step('{1'b0,1'b0,1'b0,32'h0,1'b0,32'h1234_5678,1'b1,32'h4,1'b0,32'h0,32'h4});
`ifdef IF_STALL_COUNT_EN
      chk("stall_count_seven", stall_count, 32'd7);
`endif
      step('{1'b1,1'b0,1'b0,32'h0,1'b1,32'h0,1'b1,32'h0,1'b0,32'h0,32'h0});
`ifdef IF_STALL_COUNT_EN
      chk("stall_count_cleared", stall_count, 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
